// File: rtl/painterengine_gpu_dma_reader_n.sv
// AXI4 burst read master: streams a linear memory region to one of CHANNELS
// consumer ports, splitting bursts at MAX_BURST beats and at 4 KB boundaries.
module painterengine_gpu_dma_reader_n #(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 256,
  parameter int TIMEOUT_BITS = 19
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_resetn,
  input  logic                           i_wire_start,
  input  logic                           i_wire_clear,
  input  logic [CHANNELS-1:0]            i_wire_router,
  input  logic [CHANNELS*32-1:0]         i_wire_address,
  input  logic [CHANNELS*32-1:0]         i_wire_length,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
  output logic [CHANNELS-1:0]            o_wire_data_valid,
  input  logic [CHANNELS-1:0]            i_wire_data_next,
  output logic                           o_wire_busy,
  output logic                           o_wire_done,
  output logic                           o_wire_error,
  output logic [2:0]                     o_wire_error_type,
  output logic [31:0]                    o_wire_beat_count,
  output logic                           o_wire_M_AXI_ARID,
  output logic [31:0]                    o_wire_M_AXI_ARADDR,
  output logic [7:0]                     o_wire_M_AXI_ARLEN,
  output logic [2:0]                     o_wire_M_AXI_ARSIZE,
  output logic [1:0]                     o_wire_M_AXI_ARBURST,
  output logic                           o_wire_M_AXI_ARLOCK,
  output logic [3:0]                     o_wire_M_AXI_ARCACHE,
  output logic [2:0]                     o_wire_M_AXI_ARPROT,
  output logic [3:0]                     o_wire_M_AXI_ARQOS,
  output logic                           o_wire_M_AXI_ARVALID,
  input  logic                           i_wire_M_AXI_ARREADY,
  input  logic                           i_wire_M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]          i_wire_M_AXI_RDATA,
  input  logic [1:0]                     i_wire_M_AXI_RRESP,
  input  logic                           i_wire_M_AXI_RLAST,
  input  logic                           i_wire_M_AXI_RVALID,
  output logic                           o_wire_M_AXI_RREADY
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [2:0] E_OK         = 3'b000;
  localparam logic [2:0] E_ROUTER     = 3'b001;
  localparam logic [2:0] E_ADDR_LEN   = 3'b010;
  localparam logic [2:0] E_AR_TIMEOUT = 3'b011;
  localparam logic [2:0] E_R_TIMEOUT  = 3'b100;
  localparam logic [2:0] E_PROTOCOL   = 3'b101;
  localparam logic [2:0] E_SLAVE      = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             remaining_q, remaining_d;
  logic [8:0]              len_q, len_d;
  logic [8:0]              burst_ctr_q, burst_ctr_d;
  logic [31:0]             beat_count_q, beat_count_d;
  logic [2:0]              error_type_q, error_type_d;
  logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;
  logic                    arvalid_q, arvalid_d;
  logic [31:0]             araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;

  logic [IDX_W-1:0] router_idx;
  logic             router_onehot;
  logic [31:0]      page_beats;
  logic [8:0]       burst_len;
  logic             r_hs;
  logic             timed_out;
  logic             last_beat;
  logic             unused_rid;

  assign unused_rid = i_wire_M_AXI_RID;

  always_comb begin
    router_idx = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (i_wire_router[i]) router_idx = IDX_W'(i);
  end

  assign router_onehot = (i_wire_router != '0) &&
                         ((i_wire_router & (i_wire_router - CHANNELS'(1))) == '0);

  // Beats left before the next 4 KB page; addr_q is always beat-aligned here.
  assign page_beats = (32'd4096 - {20'd0, addr_q[11:0]}) >> BYTE_SHIFT;

  always_comb begin
    burst_len = 9'(MAX_BURST);
    if (remaining_q < 32'(MAX_BURST)) burst_len = remaining_q[8:0];
    if (page_beats < {23'd0, burst_len}) burst_len = page_beats[8:0];
  end

  assign o_wire_M_AXI_RREADY = (state_q == S_DATA) && i_wire_data_next[idx_q];
  assign r_hs      = i_wire_M_AXI_RVALID && o_wire_M_AXI_RREADY;
  assign timed_out = timeout_q[TIMEOUT_BITS-1];
  assign last_beat = (burst_ctr_q == len_q - 9'd1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    burst_ctr_d  = burst_ctr_q;
    beat_count_d = beat_count_q;
    error_type_d = error_type_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    timeout_d    = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_wire_start) begin
          idx_d        = router_idx;
          addr_d       = i_wire_address[router_idx*32 +: 32];
          remaining_d  = i_wire_length[router_idx*32 +: 32];
          beat_count_d = '0;
          error_type_d = E_OK;
          if (router_onehot) begin
            state_d = S_CHECK;
          end else begin
            state_d      = S_ERROR;
            error_type_d = E_ROUTER;
          end
        end
      end
      S_CHECK: begin
        if (addr_q[BYTE_SHIFT-1:0] != '0 || remaining_q == '0) begin
          state_d      = S_ERROR;
          error_type_d = E_ADDR_LEN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        len_d       = burst_len;
        burst_ctr_d = '0;
        arvalid_d   = 1'b1;
        araddr_d    = addr_q;
        arlen_d     = 8'(burst_len - 9'd1);
        state_d     = S_ADDR;
      end
      S_ADDR: begin
        if (timed_out) begin
          arvalid_d    = 1'b0;
          state_d      = S_ERROR;
          error_type_d = E_AR_TIMEOUT;
        end else if (i_wire_M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (timed_out) begin
          state_d      = S_ERROR;
          error_type_d = E_R_TIMEOUT;
        end else if (r_hs) begin
          if (i_wire_M_AXI_RRESP != 2'b00) begin
            state_d      = S_ERROR;
            error_type_d = E_SLAVE;
          end else if (i_wire_M_AXI_RLAST != last_beat) begin
            state_d      = S_ERROR;
            error_type_d = E_PROTOCOL;
          end else begin
            burst_ctr_d  = burst_ctr_q + 9'd1;
            beat_count_d = beat_count_q + 32'd1;
            if (last_beat) begin
              addr_d      = addr_q + ({23'd0, len_q} << BYTE_SHIFT);
              remaining_d = remaining_q - {23'd0, len_q};
              state_d     = (remaining_q == {23'd0, len_q}) ? S_DONE : S_CALC;
            end
          end
        end
      end
      S_ERROR: begin
        if (i_wire_clear) begin
          state_d      = S_IDLE;
          error_type_d = E_OK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The watchdog only runs while waiting on the slave in one state.
    if (state_d == state_q &&
        ((state_q == S_ADDR && !i_wire_M_AXI_ARREADY) || (state_q == S_DATA && !r_hs)))
      timeout_d = timeout_q + TIMEOUT_BITS'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      burst_ctr_q  <= '0;
      beat_count_q <= '0;
      error_type_q <= E_OK;
      timeout_q    <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      burst_ctr_q  <= burst_ctr_d;
      beat_count_q <= beat_count_d;
      error_type_q <= error_type_d;
      timeout_q    <= timeout_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
    end
  end

  // Routing follows the latched channel, never the live router input.
  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    if (state_q == S_DATA) begin
      o_wire_data[idx_q*DATA_WIDTH +: DATA_WIDTH] = i_wire_M_AXI_RDATA;
      o_wire_data_valid[idx_q]                    = i_wire_M_AXI_RVALID;
    end
  end

  assign o_wire_busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign o_wire_done       = (state_q == S_DONE);
  assign o_wire_error      = (state_q == S_ERROR);
  assign o_wire_error_type = error_type_q;
  assign o_wire_beat_count = beat_count_q;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_q;
  assign o_wire_M_AXI_ARLEN   = arlen_q;
  assign o_wire_M_AXI_ARSIZE  = 3'(BYTE_SHIFT);
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = arvalid_q;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_n.sv
// Randomised bench: a burst-plan model and a simple AXI slave check the reader
// against expected bursts, routed beats and error codes.
module tb_painterengine_gpu_dma_reader_n;

  localparam int CH       = 4;
  localparam int DW       = 64;
  localparam int MB       = 16;
  localparam int TO_BITS  = 8;
  localparam int BYTES    = DW / 8;
  localparam int TO_LIMIT = 1 << (TO_BITS - 1);

  typedef enum int {M_OK, M_NO_LAST, M_EARLY_LAST, M_BAD_RESP, M_AR_STALL, M_R_STALL} mode_e;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, clear = 1'b0;
  logic [CH-1:0]     router = '0;
  logic [CH*32-1:0]  address = '0, length = '0;
  logic [CH*DW-1:0]  data;
  logic [CH-1:0]     data_valid;
  logic [CH-1:0]     data_next = '0;
  logic              busy, done, error;
  logic [2:0]        error_type;
  logic [31:0]       beat_count;
  logic              arid, arlock, arvalid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst;
  logic [3:0]        arcache, arqos;
  logic              arready = 1'b0, rid = 1'b0;
  logic [DW-1:0]     rdata = '0;
  logic [1:0]        rresp = 2'b00;
  logic              rlast = 1'b0, rvalid = 1'b0;
  logic              rready;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_addr[$];
  int unsigned exp_len[$];

  painterengine_gpu_dma_reader_n #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n),
    .i_wire_start(start), .i_wire_clear(clear), .i_wire_router(router),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
    .o_wire_error_type(error_type), .o_wire_beat_count(beat_count),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference burst plan: cap each burst by remaining beats, MAX_BURST and the 4 KB page.
  function automatic void build_plan(input int unsigned addr, input int unsigned len);
    int unsigned a = addr;
    int unsigned rem = len;
    int unsigned n, room;
    exp_addr.delete();
    exp_len.delete();
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / BYTES;
      n = rem;
      if (n > MB) n = MB;
      if (n > room) n = room;
      exp_addr.push_back(a);
      exp_len.push_back(n);
      a += n * BYTES;
      rem -= n;
    end
  endfunction

  task automatic do_start(input logic [CH-1:0] rt, input int ch,
                          input logic [31:0] addr, input logic [31:0] len);
    for (int c = 0; c < CH; c++) begin
      address[c*32 +: 32] = $urandom;
      length[c*32 +: 32]  = $urandom_range(1, 1000);
    end
    address[ch*32 +: 32] = addr;
    length[ch*32 +: 32]  = len;
    router = rt;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("clear_error", error, 1'b0);
    check("clear_type", error_type, 3'b000);
    check("clear_busy", busy, 1'b0);
  endtask

  task automatic start_expect_error(input logic [CH-1:0] rt, input int ch,
                                    input logic [31:0] addr, input logic [31:0] len,
                                    input logic [2:0] code);
    do_start(rt, ch, addr, len);
    repeat (3) @(negedge clk);
    check("err_flag", error, 1'b1);
    check("err_code", error_type, code);
    check("err_busy", busy, 1'b0);
  endtask

  task automatic run_transfer(input int ch, input logic [31:0] addr, input int unsigned len,
                              input mode_e mode, input logic [2:0] exp_err);
    int unsigned s_len = 0, s_beat = 0, beats = 0, burst_no = 0, plan_n;
    int ar_first = -1, err_cyc = 0;
    bit s_active = 0, ar_wait = 0, finished = 0;
    logic [31:0] held_addr = '0;
    logic [CH-1:0] want_valid;
    build_plan(addr, len);
    plan_n = exp_addr.size();
    do_start(CH'(1) << ch, ch, addr, len);
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      arready   = (mode == M_AR_STALL) ? 1'b0 : 1'($urandom_range(0, 1));
      data_next = (mode == M_R_STALL) ? '0 : CH'($urandom);
      router    = CH'($urandom);
      rdata     = {$urandom, $urandom};
      rvalid    = s_active && (mode == M_R_STALL || $urandom_range(0, 3) != 0);
      rlast     = 1'b0;
      rresp     = 2'b00;
      if (rvalid) begin
        rlast = (s_beat == s_len - 1);
        if (mode == M_NO_LAST && exp_addr.size() == 0) rlast = 1'b0;
        if (mode == M_EARLY_LAST && burst_no == 1 && s_beat == 0) rlast = 1'b1;
        if (mode == M_BAD_RESP && beats == 2) rresp = 2'b10;
      end
      #1;
      if (done || error) begin
        finished = 1;
        err_cyc  = cyc;
      end else begin
        want_valid = s_active ? (CH'(rvalid) << ch) : '0;
        check("data_valid", data_valid, want_valid);
        check("rready", rready, s_active & data_next[ch]);
        if (s_active)
          for (int c = 0; c < CH; c++)
            check("data", data[c*DW +: DW], (c == ch) ? rdata : '0);
        if (ar_wait) begin
          check("arvalid_held", arvalid, 1'b1);
          check("araddr_held", araddr, held_addr);
        end
        ar_wait   = arvalid && !arready;
        held_addr = araddr;
        if (arvalid && ar_first < 0) ar_first = cyc;
        if (arvalid && arready) begin
          burst_no++;
          if (exp_addr.size() != 0) begin
            check("araddr", araddr, exp_addr[0]);
            check("arlen", arlen, exp_len[0] - 1);
            s_len = exp_len.pop_front();
            void'(exp_addr.pop_front());
            s_beat   = 0;
            s_active = 1;
          end
        end
        if (rvalid && rready) begin
          s_beat++;
          beats++;
          if (s_beat == s_len) s_active = 0;
        end
      end
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0; data_next = '0;
    check("finished_in_budget", finished, 1'b1);
    check("error_type", error_type, exp_err);
    check("busy_end", busy, 1'b0);
    if (exp_err == 3'b000) begin
      check("done", done, 1'b1);
      check("beat_count", beat_count, len);
      check("bursts_issued", burst_no, plan_n);
    end else begin
      check("error", error, 1'b1);
    end
    if (mode == M_AR_STALL)
      check("ar_timeout_window",
            (err_cyc - ar_first >= TO_LIMIT) && (err_cyc - ar_first <= TO_LIMIT + 2), 1'b1);
    if (exp_err != 3'b000) do_clear();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_arlen", arlen, 8'h0);
    check("rst_error_type", error_type, 3'b000);
    check("rst_beat_count", beat_count, 32'h0);
    check("rst_flags", {busy, done, error}, 3'b000);
    check("rst_data_valid", data_valid, '0);
    check("rst_rready", rready, 1'b0);
    check("arsize", arsize, 3'd3);
    check("arburst", arburst, 2'b01);
    check("arcache", arcache, 4'b0010);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed bursts: single burst, 4 KB split, MAX_BURST split.
    run_transfer(1, 32'h0000_1000, 16, M_OK, 3'b000);
    run_transfer(2, 32'h0000_0FF0, 10, M_OK, 3'b000);
    run_transfer(0, 32'h0000_0000, 40, M_OK, 3'b000);

    // Router not one-hot; ERROR is sticky against start; clear beats start.
    start_expect_error(4'b0011, 0, 32'h1000, 8, 3'b001);
    do_start(4'b0100, 2, 32'h2000, 8);
    repeat (2) @(negedge clk);
    check("sticky_error", error, 1'b1);
    check("sticky_type", error_type, 3'b001);
    router = 4'b0001; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    check("clear_wins_busy", busy, 1'b0);
    check("clear_wins_error", error, 1'b0);
    check("clear_wins_type", error_type, 3'b000);
    run_transfer(3, 32'h0000_2000, 12, M_OK, 3'b000);

    start_expect_error(4'b0010, 1, 32'h0000_1004, 16, 3'b010);
    do_clear();
    start_expect_error(4'b0010, 1, 32'h0000_1000, 0, 3'b010);
    do_clear();

    run_transfer(0, 32'h0000_5000, 20, M_NO_LAST, 3'b101);
    run_transfer(1, 32'h0000_3000, 20, M_EARLY_LAST, 3'b101);
    run_transfer(2, 32'h0000_4000, 8, M_BAD_RESP, 3'b110);
    run_transfer(3, 32'h0000_7000, 8, M_AR_STALL, 3'b011);
    run_transfer(1, 32'h0000_8000, 8, M_R_STALL, 3'b100);

    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      if (t % 2 == 0) a = $urandom & 32'hFFFF_FFF8;
      else a = ($urandom_range(0, 255) << 12) | (4096 - 8 * $urandom_range(1, 40));
      run_transfer($urandom_range(0, CH - 1), a, $urandom_range(1, 70), M_OK, 3'b000);
    end

    // Asynchronous reset in the middle of a burst.
    do_start(4'b0001, 0, 32'h0000_6000, 32);
    arready = 1'b1; data_next = '1;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_arvalid", arvalid, 1'b0);
    check("reset_beat_count", beat_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; arready = 1'b0; data_next = '0;
    @(negedge clk);
    run_transfer(2, 32'h0000_9FF8, 5, M_OK, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
